button_pulse_gen: RTL and testbench

Front-end conditioner for the board push-buttons. It synchronizes N raw button inputs to `clk`, debounces each channel independently, and emits a debounced level plus a single-cycle press pulse per channel. It sits directly upstream of the register-rotation datapath and drives its `btn2`/`btn1`/`btn0` inputs with `btn_pulse[2:0]`. Each physical press therefore causes exactly one load or rotate step, not one per clock while the button is held.

---
 rtl/button_pulse_gen.sv | 73 +++++++
 tb/tb_button_pulse_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// Push-button front end: two-flop synchronizer, per-channel debounce counter,
// and a registered one-cycle pulse on every accepted press.
module button_pulse_gen #(
    parameter int N               = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         async_reset,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic                 level_q;
        logic                 level_d;
        logic                 pulse_q;
        logic                 pulse_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;

        // An agreeing sample restarts the window; a full window of disagreeing samples flips the level.
        always_comb begin
            // NOTE: defaults first so every path assigns every output and no latch is inferred.
            level_d = level_q;
            cnt_d   = '0;
            pulse_d = 1'b0;
            if (sync2_q[i] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = '0;
                pulse_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        always_ff @(posedge clk or posedge async_reset) begin
            if (async_reset) begin
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                level_q <= level_d;
                pulse_q <= pulse_d;
                cnt_q   <= cnt_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE_CYCLES=4, N=3.
module tb_button_pulse_gen;

    localparam int N = 3;
    localparam int DB = 4;

    logic         clk;
    logic         async_reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    button_pulse_gen #(
        .N              (N),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] pls;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] raw, input logic [N-1:0] lvl,
                       input logic [N-1:0] pls, input int n);
        vec_t v;
        v.raw = raw;
        v.lvl = lvl;
        v.pls = pls;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic step_check(input string name, input logic [N-1:0] lvl, input logic [N-1:0] pls);
        @(posedge clk);
        #1;
        check({name, " level"}, btn_level, lvl);
        check({name, " pulse"}, btn_pulse, pls);
    endtask

    initial begin
        // Clean press on channel 0, then release.
        add(3'b001, 3'b000, 3'b000, 5);
        add(3'b001, 3'b001, 3'b001, 1);
        add(3'b001, 3'b001, 3'b000, 2);
        add(3'b000, 3'b001, 3'b000, 5);
        add(3'b000, 3'b000, 3'b000, 3);
        // Bounce on channel 1: samples 1,1,1,0 then steady 1.
        add(3'b010, 3'b000, 3'b000, 3);
        add(3'b000, 3'b000, 3'b000, 1);
        add(3'b010, 3'b000, 3'b000, 5);
        add(3'b010, 3'b010, 3'b010, 1);
        add(3'b010, 3'b010, 3'b000, 1);
        add(3'b000, 3'b010, 3'b000, 5);
        add(3'b000, 3'b000, 3'b000, 3);
        // Three-cycle glitch on channel 2 never qualifies.
        add(3'b100, 3'b000, 3'b000, 3);
        add(3'b000, 3'b000, 3'b000, 6);
        // All channels together.
        add(3'b111, 3'b000, 3'b000, 5);
        add(3'b111, 3'b111, 3'b111, 1);
        add(3'b111, 3'b111, 3'b000, 2);
        add(3'b000, 3'b111, 3'b000, 5);
        add(3'b000, 3'b000, 3'b000, 3);

        // Reset applied before any clock edge clears outputs at once.
        async_reset = 1'b1;
        btn_raw     = '0;
        #2;
        check("reset async level", btn_level, 3'b000);
        check("reset async pulse", btn_pulse, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        async_reset = 1'b0;
        for (int k = 0; k < 20; k++) step_check($sformatf("idle %0d", k), 3'b000, 3'b000);

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            step_check($sformatf("vec %0d", i), vecs[i].lvl, vecs[i].pls);
        end

        // Reset while channel 0 is pressed and held.
        btn_raw = 3'b001;
        for (int k = 1; k <= 5; k++) step_check($sformatf("hold %0d", k), 3'b000, 3'b000);
        step_check("hold accept", 3'b001, 3'b001);
        step_check("hold steady", 3'b001, 3'b000);
        #3;
        async_reset = 1'b1;
        #1;
        check("midreset level", btn_level, 3'b000);
        check("midreset pulse", btn_pulse, 3'b000);
        for (int k = 0; k < 2; k++) step_check($sformatf("in reset %0d", k), 3'b000, 3'b000);
        async_reset = 1'b0;
        for (int k = 1; k <= 5; k++) step_check($sformatf("repress %0d", k), 3'b000, 3'b000);
        step_check("repress accept", 3'b001, 3'b001);
        step_check("repress steady", 3'b001, 3'b000);
        step_check("repress hold", 3'b001, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
